// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO serial transmitter and its planned receiver.
// Holds the 3-bit FSM state encodings, the idle line level and the default bit
// period in clocks.
package fifo_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    POP    = ST_POP,
    LOAD   = ST_LOAD,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam int   DIV_DEFAULT   = 4;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read-side handshake between the word FIFO and the serial transmitter.
//   fifo_empty : FIFO empty flag (driven by the FIFO)
//   fifo_rd_en : pop strobe (driven by the transmitter)
//   fifo_data  : FIFO data_out, valid the cycle after the pop edge
// master = transmitter side, slave = FIFO side.
interface fifo_serial_tx_if #(
  parameter int DATA_W = 4
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and wraps, raising 'tick' during count DIV-1.
// 'clr' holds the count at zero so each bit starts on a fresh period.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear
//   tick     : high in the last clock of a bit period
module bit_timer #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Read side of the word FIFO: pops one word when enabled and the FIFO is not
// empty, then sends it as start(0), data LSB-first, optional even parity,
// stop(1), each bit DIV clocks long.
//   clk, rst   : clock, async active-high reset
//   enable     : permits new pops, looked at only in IDLE
//   fifo       : FIFO read handshake (master side)
//   tx         : serial line, idles high, registered
//   busy       : high outside IDLE
//   frame_done : one-cycle pulse in the last clock of the stop bit
//   word_count : frames sent since reset, wraps at 255
//
// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty FIFO
// POP    | one-cycle FIFO read strobe
// LOAD   | capture FIFO data and its parity
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | even parity bit (only when PARITY_EN)
// STOP   | stop bit (1), frame_done in its last clock
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int DIV       = DIV_DEFAULT,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  fifo_serial_tx_if.master  fifo,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        word_count
);

  localparam int              BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic [7:0]        word_count_q, word_count_d;
  logic              tick;
  logic              timer_clr;

  // The timer only runs while a bit is on the line; it is cleared in the
  // non-bit states so START always begins at count 0.
  assign timer_clr = !(state_q inside {START, DATA, PARITY, STOP});

  bit_timer #(
    .DIV   (DIV),
    .CNT_W (8)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    bit_cnt_d    = bit_cnt_q;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        if (enable && !fifo.fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo.fifo_data;
        parity_d  = ^fifo.fifo_data;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          word_count_d = word_count_q + 8'd1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // tx is registered from the next state so the pin only moves on bit
    // boundaries and never glitches on state decode.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      bit_cnt_q    <= '0;
      tx_q         <= TX_IDLE_LEVEL;
      word_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      word_count_q <= word_count_d;
    end
  end

  assign fifo.fifo_rd_en = (state_q == POP);
  assign busy            = (state_q != IDLE);
  assign frame_done      = (state_q == STOP) && tick;
  assign tx              = tx_q;
  assign word_count      = word_count_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx. Three instances share clk/rst:
//   0: DIV=4, no parity   1: DIV=4, parity   2: DIV=2, no parity (wrap run)
// Each instance is fed by a small 8-deep FIFO model in this bench.
module tb_fifo_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic       en_v [3] = '{1'b1, 1'b1, 1'b1};
  logic [3:0] mem [3][8];
  int         wr_p [3] = '{0, 0, 0};
  int         rd_p [3] = '{0, 0, 0};
  logic [3:0] dout [3] = '{4'h0, 4'h0, 4'h0};
  int         pops [3] = '{0, 0, 0};
  int         dones[3] = '{0, 0, 0};

  logic       rd_en_v[3], tx_v[3], busy_v[3], done_v[3], empty_v[3];
  logic [7:0] wc_v[3];
  logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
  logic [7:0] wc0, wc1, wc2;

  fifo_serial_tx_if #(.DATA_W(4)) if0 ();
  fifo_serial_tx_if #(.DATA_W(4)) if1 ();
  fifo_serial_tx_if #(.DATA_W(4)) if2 ();

  assign if0.fifo_empty = (wr_p[0] == rd_p[0]);
  assign if1.fifo_empty = (wr_p[1] == rd_p[1]);
  assign if2.fifo_empty = (wr_p[2] == rd_p[2]);
  assign if0.fifo_data  = dout[0];
  assign if1.fifo_data  = dout[1];
  assign if2.fifo_data  = dout[2];

  assign rd_en_v[0] = if0.fifo_rd_en;
  assign rd_en_v[1] = if1.fifo_rd_en;
  assign rd_en_v[2] = if2.fifo_rd_en;
  assign empty_v[0] = if0.fifo_empty;
  assign empty_v[1] = if1.fifo_empty;
  assign empty_v[2] = if2.fifo_empty;
  assign tx_v[0] = tx0;     assign tx_v[1] = tx1;     assign tx_v[2] = tx2;
  assign busy_v[0] = busy0; assign busy_v[1] = busy1; assign busy_v[2] = busy2;
  assign done_v[0] = done0; assign done_v[1] = done1; assign done_v[2] = done2;
  assign wc_v[0] = wc0;     assign wc_v[1] = wc1;     assign wc_v[2] = wc2;

  fifo_serial_tx #(.DATA_W(4), .DIV(4), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .enable(en_v[0]), .fifo(if0.master),
    .tx(tx0), .busy(busy0), .frame_done(done0), .word_count(wc0));

  fifo_serial_tx #(.DATA_W(4), .DIV(4), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(en_v[1]), .fifo(if1.master),
    .tx(tx1), .busy(busy1), .frame_done(done1), .word_count(wc1));

  fifo_serial_tx #(.DATA_W(4), .DIV(2), .PARITY_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .enable(en_v[2]), .fifo(if2.master),
    .tx(tx2), .busy(busy2), .frame_done(done2), .word_count(wc2));

  // FIFO read side: data_out updates on the pop edge, zero when read empty.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rd_en_v[i]) begin
        pops[i] <= pops[i] + 1;
        if (wr_p[i] != rd_p[i]) begin
          dout[i] <= mem[i][rd_p[i] % 8];
          rd_p[i] <= rd_p[i] + 1;
        end else begin
          dout[i] <= 4'h0;
        end
      end
      if (done_v[i]) dones[i] <= dones[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [3:0] w);
    mem[i][wr_p[i] % 8] = w;
    wr_p[i] = wr_p[i] + 1;
  endtask

  // Waits for the pop of word w, then checks every clock of the frame on tx.
  // drop_bit >= 0 lowers enable at the first clock of that frame bit.
  task automatic frame(input int i, input logic [3:0] w, input int exp_len,
                       input int drop_bit, input string tag, output int pop_cyc);
    logic bits[$];
    int   div;
    int   len;
    bit   seen;
    pop_cyc = 0;
    div  = (i == 2) ? 2 : 4;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (rd_en_v[i]) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_pop_timeout"}, 32'd0, 32'd1);
      return;
    end
    pop_cyc = cyc;
    len = 1;
    @(negedge clk);
    len++;
    chk({tag, "_load_tx"}, tx_v[i], 1);
    chk({tag, "_single_pop"}, rd_en_v[i], 0);
    bits.push_back(1'b0);
    for (int b = 0; b < 4; b++) bits.push_back(w[b]);
    if (i == 1) bits.push_back(^w);
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < div; k++) begin
        @(negedge clk);
        len++;
        if (b == drop_bit && k == 0) en_v[i] = 1'b0;
        chk({tag, "_tx"}, tx_v[i], bits[b]);
        chk({tag, "_done"}, done_v[i], (b == bits.size() - 1 && k == div - 1) ? 1 : 0);
      end
    end
    chk({tag, "_len"}, len, exp_len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p1, p2, p3, pushed;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", tx_v[i], 1);
      chk("rst_busy", busy_v[i], 0);
      chk("rst_rd_en", rd_en_v[i], 0);
      chk("rst_wc", wc_v[i], 0);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_no_pop", pops[0] + pops[1] + pops[2], 0);
    chk("idle_tx", tx_v[0], 1);

    // single word, no parity: 2 + 4*6 = 26 cycles from pop to frame_done
    push(0, 4'b1011);
    frame(0, 4'b1011, 26, -1, "t2", p1);
    @(negedge clk);
    chk("t2_wc", wc_v[0], 1);
    chk("t2_busy", busy_v[0], 0);
    chk("t2_pops", pops[0], 1);
    chk("t2_dones", dones[0], 1);

    // parity: 0111 -> parity 1, 2 + 4*7 = 30 cycles
    push(1, 4'b0111);
    frame(1, 4'b0111, 30, -1, "t3", p1);
    @(negedge clk);
    chk("t3_wc", wc_v[1], 1);
    chk("t3_dones", dones[1], 1);

    // back-to-back: 27-cycle pop spacing
    push(0, 4'h5);
    push(0, 4'hA);
    push(0, 4'h3);
    frame(0, 4'h5, 26, -1, "t4a", p1);
    frame(0, 4'hA, 26, -1, "t4b", p2);
    frame(0, 4'h3, 26, -1, "t4c", p3);
    chk("t4_gap1", p2 - p1, 27);
    chk("t4_gap2", p3 - p2, 27);
    chk("t4_empty", empty_v[0], 1);
    repeat (10) @(negedge clk);
    chk("t4_pops", pops[0], 4);
    chk("t4_wc", wc_v[0], 4);

    // enable dropped during the first data bit of word 1
    push(0, 4'h9);
    push(0, 4'h6);
    push(0, 4'hC);
    frame(0, 4'h9, 26, 1, "t5a", p1);
    repeat (40) @(negedge clk);
    chk("t5_pops_held", pops[0], 5);
    chk("t5_busy", busy_v[0], 0);
    chk("t5_not_empty", empty_v[0], 0);
    chk("t5_wc", wc_v[0], 5);
    en_v[0] = 1'b1;
    frame(0, 4'h6, 26, -1, "t5b", p1);
    frame(0, 4'hC, 26, -1, "t5c", p2);
    @(negedge clk);
    chk("t5_wc_end", wc_v[0], 7);
    chk("t5_pops_end", pops[0], 7);

    // word_count wrap on the DIV=2 instance: 256 frames
    pushed = 0;
    for (int t = 0; t < 8000 && pushed < 256; t++) begin
      @(negedge clk);
      if (wr_p[2] - rd_p[2] < 8) begin
        push(2, pushed[3:0]);
        pushed++;
      end
    end
    chk("t6_pushed", pushed, 256);
    for (int t = 0; t < 2000 && dones[2] < 255; t++) @(negedge clk);
    chk("t6_wc_255", wc_v[2], 255);
    for (int t = 0; t < 200 && dones[2] < 256; t++) @(negedge clk);
    @(negedge clk);
    chk("t6_wc_wrap", wc_v[2], 0);
    chk("t6_dones", dones[2], 256);
    chk("t6_pops", pops[2], 256);

    // reset in the middle of a start bit
    push(0, 4'hE);
    p1 = 0;
    for (int t = 0; t < 60 && p1 == 0; t++) begin
      @(negedge clk);
      if (rd_en_v[0]) p1 = 1;
    end
    chk("t1_pop_seen", p1, 1);
    repeat (3) @(negedge clk);
    chk("t1_pre_tx", tx_v[0], 0);
    chk("t1_pre_busy", busy_v[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_tx", tx_v[0], 1);
    chk("t1_busy", busy_v[0], 0);
    chk("t1_rd_en", rd_en_v[0], 0);
    chk("t1_wc0", wc_v[0], 0);
    chk("t1_wc1", wc_v[1], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_no_pop_empty", pops[0], 8);
    chk("t1_idle_busy", busy_v[0], 0);
    chk("t1_idle_tx", tx_v[0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
